genius_seq_engine: RTL and testbench



---
 rtl/genius_seq_engine.sv | 176 +++++++++++++++++
 tb/tb_genius_seq_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/genius_seq_engine.sv
// Simon-style sequence engine: grows an LFSR-derived sequence each round, replays it, then checks presses with a per-press timeout.
// Start -> ADD next cycle, LEDs from the cycle after; a press updates state one cycle later; no backpressure (pulse inputs).
module genius_seq_engine #(
  parameter int          N_CH          = 4,
  parameter int          DEPTH         = 16,
  parameter int          SHOW_TICKS    = 2,
  parameter int          GAP_TICKS     = 1,
  parameter int          TIMEOUT_TICKS = 5,
  parameter logic [15:0] SEED          = 16'hACE1,
  localparam int         CW            = $clog2(N_CH),
  localparam int         RW            = $clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            r_i,
  input  logic            start_i,
  input  logic            tick_i,
  input  logic [N_CH-1:0] btn_i,
  input  logic [RW-1:0]   goal_i,
  output logic [N_CH-1:0] leds_o,
  output logic [RW-1:0]   round_o,
  output logic [3:0]      time_o,
  output logic            busy_o,
  output logic            win_o,
  output logic            lose_o
);

  localparam int IW   = RW - 1;
  localparam int MAXT = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(MAXT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_WIN, S_LOSE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q;
  logic [CW-1:0]   mem [DEPTH];
  logic [RW-1:0]   round_q, goal_q, goal_clamp;
  logic [IW-1:0]   idx_q;
  logic [TW-1:0]   cnt_q;
  logic [3:0]      timer_q;
  logic [CW-1:0]   cur_item;
  logic [N_CH-1:0] cur_oh;
  logic            press, correct, last, show_done, gap_done, timeout;

  assign cur_item  = mem[idx_q];
  assign cur_oh    = {{(N_CH-1){1'b0}}, 1'b1} << cur_item;
  assign press     = |btn_i;
  assign correct   = (btn_i == cur_oh);
  assign last      = ({1'b0, idx_q} == (round_q - RW'(1)));
  assign show_done = tick_i && (cnt_q == TW'(SHOW_TICKS - 1));
  assign gap_done  = tick_i && (cnt_q == TW'(GAP_TICKS - 1));
  assign timeout   = tick_i && !press && (timer_q == 4'd1);

  // Goal is clamped so the round counter can never index past the memory.
  always_comb begin
    goal_clamp = goal_i;
    if (goal_i == '0)
      goal_clamp = RW'(1);
    else if (goal_i > RW'(DEPTH))
      goal_clamp = RW'(DEPTH);
  end

  always_ff @(posedge clk_i or negedge r_i) begin
    if (!r_i)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: if (start_i) state_d = S_ADD;
      S_ADD:                 state_d = S_SHOW_ON;
      S_SHOW_ON:             if (show_done) state_d = S_SHOW_OFF;
      S_SHOW_OFF:            if (gap_done) state_d = last ? S_INPUT : S_SHOW_ON;
      S_INPUT: begin
        if (press) begin
          if (!correct)
            state_d = S_LOSE;
          else if (last)
            state_d = (round_q == goal_q) ? S_WIN : S_ADD;
        end else if (timeout) begin
          state_d = S_LOSE;
        end
      end
      default:               state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge r_i) begin
    if (!r_i) begin
      lfsr_q  <= SEED;
      round_q <= '0;
      goal_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      case (state_q)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start_i) begin
            round_q <= '0;
            goal_q  <= goal_clamp;
          end
        end
        S_ADD: begin
          round_q <= round_q + RW'(1);
          idx_q   <= '0;
          cnt_q   <= '0;
        end
        S_SHOW_ON: begin
          if (tick_i) cnt_q <= show_done ? '0 : cnt_q + TW'(1);
        end
        S_SHOW_OFF: begin
          if (gap_done) begin
            cnt_q <= '0;
            if (last) begin
              idx_q   <= '0;
              timer_q <= 4'(TIMEOUT_TICKS);
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end else if (tick_i) begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        S_INPUT: begin
          // A press in the same cycle as a tick takes priority and reloads.
          if (press) begin
            if (correct) begin
              timer_q <= 4'(TIMEOUT_TICKS);
              if (!last) idx_q <= idx_q + IW'(1);
            end
          end else if (tick_i) begin
            timer_q <= timer_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == S_ADD)
      mem[round_q[IW-1:0]] <= lfsr_q[CW-1:0];
  end

  always_comb begin
    leds_o  = '0;
    round_o = round_q;
    time_o  = '0;
    busy_o  = 1'b0;
    win_o   = 1'b0;
    lose_o  = 1'b0;
    case (state_q)
      S_IDLE:     round_o = '0;
      S_ADD:      busy_o  = 1'b1;
      S_SHOW_ON: begin
        busy_o = 1'b1;
        leds_o = cur_oh;
      end
      S_SHOW_OFF: busy_o  = 1'b1;
      S_INPUT: begin
        busy_o = 1'b1;
        time_o = timer_q;
      end
      S_WIN:      win_o   = 1'b1;
      S_LOSE:     lose_o  = 1'b1;
      default:    round_o = '0;
    endcase
  end

endmodule

// File: tb/tb_genius_seq_engine.sv
// Directed game scenarios with randomized tick spacing and wrong buttons, checked against an LFSR/sequence reference model.
module tb_genius_seq_engine;

  localparam int          N_CH          = 4;
  localparam int          DEPTH         = 16;
  localparam int          SHOW_TICKS    = 2;
  localparam int          GAP_TICKS     = 1;
  localparam int          TIMEOUT_TICKS = 5;
  localparam logic [15:0] SEED          = 16'hACE1;
  localparam int          CW            = 2;
  localparam int          RW            = 5;

  logic            clk_i = 1'b0;
  logic            r_i = 1'b1;
  logic            start_i = 1'b0;
  logic            tick_i = 1'b0;
  logic [N_CH-1:0] btn_i = '0;
  logic [RW-1:0]   goal_i = '0;
  logic [N_CH-1:0] leds_o;
  logic [RW-1:0]   round_o;
  logic [3:0]      time_o;
  logic            busy_o, win_o, lose_o;

  int tests = 0;
  int fails = 0;

  logic [15:0]     model_lfsr;
  int              exp_q[$];
  logic [N_CH-1:0] shown_q[$];
  logic [N_CH-1:0] prev_shown[$];

  genius_seq_engine #(
    .N_CH(N_CH), .DEPTH(DEPTH), .SHOW_TICKS(SHOW_TICKS), .GAP_TICKS(GAP_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS), .SEED(SEED)
  ) dut (
    .clk_i(clk_i), .r_i(r_i), .start_i(start_i), .tick_i(tick_i), .btn_i(btn_i),
    .goal_i(goal_i), .leds_o(leds_o), .round_o(round_o), .time_o(time_o),
    .busy_o(busy_o), .win_o(win_o), .lose_o(lose_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    int   taps[4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[k]) fb = fb ^ x[taps[k]-1];
    return {x[14:0], fb};
  endfunction

  // Reference LFSR: advances once per clock from the seed while reset is released.
  always @(posedge clk_i or negedge r_i) begin
    if (!r_i) model_lfsr <= SEED;
    else      model_lfsr <= lfsr_adv(model_lfsr);
  end

  function automatic logic [N_CH-1:0] onehot(input int v);
    logic [N_CH-1:0] r = '0;
    r[v] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] all_out();
    return 32'({leds_o, round_o, time_o, busy_o, win_o, lose_o});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk_i);
    #1;
  endtask

  task automatic tick_cycle();
    tick_i = 1'b1;
    clk1();
    tick_i = 1'b0;
  endtask

  task automatic press_btn(input logic [N_CH-1:0] b, input logic tk);
    btn_i  = b;
    tick_i = tk;
    clk1();
    btn_i  = '0;
    tick_i = 1'b0;
  endtask

  task automatic do_start(input int g);
    goal_i  = RW'(g);
    start_i = 1'b1;
    clk1();
    start_i = 1'b0;
    check("add_busy", 32'(busy_o), 32'd1);
    check("add_round0", 32'(round_o), 32'd0);
    exp_q.delete();
    exp_q.push_back(int'(model_lfsr[CW-1:0]));
    clk1();
    check("start_round1", 32'(round_o), 32'd1);
  endtask

  // Replays the whole expected sequence; ends with the DUT in INPUT.
  task automatic show_seq();
    shown_q.delete();
    check("show_round", 32'(round_o), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      shown_q.push_back(leds_o);
      for (int t = 0; t < SHOW_TICKS; t++) begin
        repeat ($urandom_range(0, 1)) clk1();
        check("show_led", 32'(leds_o), 32'(onehot(exp_q[i])));
        tick_cycle();
      end
      for (int t = 0; t < GAP_TICKS; t++) begin
        repeat ($urandom_range(0, 1)) clk1();
        check("gap_led", 32'(leds_o), 32'd0);
        tick_cycle();
      end
    end
    check("input_time", 32'(time_o), 32'(TIMEOUT_TICKS));
    check("input_busy", 32'(busy_o), 32'd1);
  endtask

  // Correct presses for the whole sequence; follows into ADD/SHOW_ON or WIN.
  task automatic play_input(input int goal);
    int n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      int k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        check("time_count", 32'(time_o), 32'(TIMEOUT_TICKS - j));
        tick_cycle();
      end
      press_btn(onehot(exp_q[i]), 1'b0);
      if (i < n - 1) begin
        check("press_reload", 32'(time_o), 32'(TIMEOUT_TICKS));
        check("press_nolose", 32'(lose_o), 32'd0);
      end else if (n == goal) begin
        check("win", 32'(win_o), 32'd1);
        check("win_busy", 32'(busy_o), 32'd0);
        check("win_round", 32'(round_o), 32'(n));
      end else begin
        check("next_add_busy", 32'(busy_o), 32'd1);
        check("next_add_round", 32'(round_o), 32'(n));
        exp_q.push_back(int'(model_lfsr[CW-1:0]));
        clk1();
        check("next_round", 32'(round_o), 32'(n + 1));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle behaviour
    #2 r_i = 1'b0;
    #1 check("reset_outs", all_out(), 32'd0);
    repeat (3) clk1();
    check("reset_hold", all_out(), 32'd0);
    r_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick_i = 1'($urandom_range(0, 1));
      btn_i  = onehot($urandom_range(0, N_CH - 1));
      clk1();
      check("idle_outs", all_out(), 32'd0);
    end
    tick_i = 1'b0;
    btn_i  = '0;

    // Full win, goal 3, with prefix property across rounds
    do_start(3);
    for (int r = 1; r <= 3; r++) begin
      show_seq();
      if (r == 3) begin
        check("prefix_len", 32'(shown_q.size()), 32'(prev_shown.size() + 1));
        for (int i = 0; i < prev_shown.size(); i++)
          check("prefix_item", 32'(shown_q[i]), 32'(prev_shown[i]));
      end
      prev_shown = shown_q;
      play_input(3);
    end
    check("win_final", 32'(win_o), 32'd1);

    // Wrong press in round 2
    do_start(5);
    show_seq();
    play_input(5);
    show_seq();
    press_btn(onehot(exp_q[0]), 1'b0);
    check("wrong_first_ok", 32'(lose_o), 32'd0);
    press_btn(onehot((exp_q[1] + 1 + int'($urandom_range(0, 2))) % N_CH), 1'b0);
    check("wrong_lose", 32'(lose_o), 32'd1);
    check("wrong_round", 32'(round_o), 32'd2);
    check("wrong_leds", 32'(leds_o), 32'd0);
    check("wrong_busy", 32'(busy_o), 32'd0);

    // Timeout
    do_start(4);
    show_seq();
    for (int k = 0; k < TIMEOUT_TICKS; k++) begin
      check("to_time", 32'(time_o), 32'(TIMEOUT_TICKS - k));
      check("to_nolose", 32'(lose_o), 32'd0);
      tick_cycle();
    end
    check("to_lose", 32'(lose_o), 32'd1);
    check("to_time0", 32'(time_o), 32'd0);

    // Press on the same cycle as the final tick
    do_start(2);
    show_seq();
    play_input(2);
    show_seq();
    for (int k = 0; k < TIMEOUT_TICKS - 1; k++) tick_cycle();
    check("same_time1", 32'(time_o), 32'd1);
    press_btn(onehot(exp_q[0]), 1'b1);
    check("same_nolose", 32'(lose_o), 32'd0);
    check("same_reload", 32'(time_o), 32'(TIMEOUT_TICKS));
    press_btn(onehot(exp_q[1]), 1'b0);
    check("same_win", 32'(win_o), 32'd1);

    // Start ignored while busy; multi-hot press loses
    do_start(3);
    goal_i  = RW'(7);
    start_i = 1'b1;
    clk1();
    start_i = 1'b0;
    check("busy_start_round", 32'(round_o), 32'd1);
    check("busy_start_leds", 32'(leds_o), 32'(onehot(exp_q[0])));
    show_seq();
    press_btn(4'b0011, 1'b0);
    check("multihot_lose", 32'(lose_o), 32'd1);
    check("multihot_round", 32'(round_o), 32'd1);

    // Goal clamp: 0 -> 1, 31 -> DEPTH
    do_start(0);
    show_seq();
    play_input(1);
    do_start(31);
    for (int r = 1; r <= DEPTH; r++) begin
      show_seq();
      play_input(DEPTH);
    end
    check("clamp_win", 32'(win_o), 32'd1);
    check("clamp_round", 32'(round_o), 32'(DEPTH));

    // Reset mid-game clears outputs without a clock edge
    do_start(3);
    repeat (2) clk1();
    r_i = 1'b0;
    #1 check("midreset_outs", all_out(), 32'd0);
    clk1();
    r_i = 1'b1;
    clk1();
    check("after_reset_idle", all_out(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
